// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: multiply latency pipe, radix-2 restoring divider, MTHI/MTLO, single-cycle HI/LO write.
// Optional macro DIV_EARLY_EXIT_EN: divides with |a| < |b| finish in cycle 1.
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] wHiData,
  output logic        whi,
  output logic [31:0] wLoData,
  output logic        wlo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [1:0]  state_r;
  logic [2:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic        qneg_r;
  logic        rneg_r;
  logic [5:0]  cnt_r;

  logic        req_s;
  logic        accept_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [32:0] shift_s;
  logic [32:0] diff_s;
  logic [31:0] nrem_s;
  logic [31:0] nquo_s;
`ifdef DIV_EARLY_EXIT_EN
  logic        small_s;
`endif

  function automatic logic [63:0] mul64(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    if (op == OP_MULT) begin
      ax = {{32{a[31]}}, a};
      bx = {{32{b[31]}}, b};
    end else begin
      ax = {32'd0, a};
      bx = {32'd0, b};
    end
    return ax * bx;
  endfunction

  // Request decode, operand magnitudes and one restoring-divide step
  always_comb begin
    req_s    = valid_i && (op_i >= OP_MULT) && (op_i <= OP_MTLO) && !flush_i;
    accept_s = req_s && (state_r == S_IDLE);
    ready_o  = (state_r == S_IDLE);
    stall_o  = (state_r != S_IDLE) || req_s;
    a_mag_s  = ((op_i == OP_DIV) && a_i[31]) ? (32'd0 - a_i) : a_i;
    b_mag_s  = ((op_i == OP_DIV) && b_i[31]) ? (32'd0 - b_i) : b_i;
    shift_s  = {rem_r, quo_r[31]};
    diff_s   = shift_s - {1'b0, dvs_r};
    if (diff_s[32]) begin
      nrem_s = shift_s[31:0];
      nquo_s = {quo_r[30:0], 1'b0};
    end else begin
      nrem_s = diff_s[31:0];
      nquo_s = {quo_r[30:0], 1'b1};
    end
`ifdef DIV_EARLY_EXIT_EN
    small_s = (a_mag_s < b_mag_s);
`endif
  end

  // Sequencer state plus registered write port; write strobes default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      op_r    <= 3'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      quo_r   <= 32'd0;
      rem_r   <= 32'd0;
      dvs_r   <= 32'd0;
      qneg_r  <= 1'b0;
      rneg_r  <= 1'b0;
      cnt_r   <= 6'd0;
      done_o  <= 1'b0;
      whi     <= 1'b0;
      wlo     <= 1'b0;
      wHiData <= 32'd0;
      wLoData <= 32'd0;
    end else begin
      done_o  <= 1'b0;
      whi     <= 1'b0;
      wlo     <= 1'b0;
      wHiData <= 32'd0;
      wLoData <= 32'd0;
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r <= op_i;
            a_r  <= a_i;
            b_r  <= b_i;
            case (op_i)
              OP_MULT, OP_MULTU: begin
                if (MUL_LAT == 1) begin
                  state_r              <= S_DONE;
                  done_o               <= 1'b1;
                  whi                  <= 1'b1;
                  wlo                  <= 1'b1;
                  {wHiData, wLoData}   <= mul64(op_i, a_i, b_i);
                end else begin
                  state_r <= S_MUL;
                  cnt_r   <= 6'(MUL_LAT - 2);
                end
              end
              OP_DIV, OP_DIVU: begin
                if (b_i == 32'd0) begin
                  state_r <= S_DONE;
                  done_o  <= 1'b1;
`ifdef DIV_EARLY_EXIT_EN
                end else if (small_s) begin
                  state_r <= S_DONE;
                  done_o  <= 1'b1;
                  whi     <= 1'b1;
                  wlo     <= 1'b1;
                  wHiData <= a_i;
`endif
                end else begin
                  state_r <= S_DIV;
                  quo_r   <= a_mag_s;
                  rem_r   <= 32'd0;
                  dvs_r   <= b_mag_s;
                  qneg_r  <= (op_i == OP_DIV) && (a_i[31] ^ b_i[31]);
                  rneg_r  <= (op_i == OP_DIV) && a_i[31];
                  cnt_r   <= 6'd0;
                end
              end
              OP_MTHI: begin
                state_r <= S_DONE;
                done_o  <= 1'b1;
                whi     <= 1'b1;
                wHiData <= a_i;
              end
              OP_MTLO: begin
                state_r <= S_DONE;
                done_o  <= 1'b1;
                wlo     <= 1'b1;
                wLoData <= a_i;
              end
              default: state_r <= S_IDLE;
            endcase
          end
        end
        S_MUL: begin
          if (flush_i) begin
            state_r <= S_IDLE;
          end else if (cnt_r == 6'd0) begin
            state_r            <= S_DONE;
            done_o             <= 1'b1;
            whi                <= 1'b1;
            wlo                <= 1'b1;
            {wHiData, wLoData} <= mul64(op_r, a_r, b_r);
          end else begin
            cnt_r <= cnt_r - 6'd1;
          end
        end
        S_DIV: begin
          if (flush_i) begin
            state_r <= S_IDLE;
          end else begin
            rem_r <= nrem_s;
            quo_r <= nquo_s;
            cnt_r <= cnt_r + 6'd1;
            // Last iteration: sign fixup folds into the registered write data
            if (cnt_r == 6'(DIV_BITS - 1)) begin
              state_r <= S_DONE;
              done_o  <= 1'b1;
              whi     <= 1'b1;
              wlo     <= 1'b1;
              wLoData <= qneg_r ? (32'd0 - nquo_s) : nquo_s;
              wHiData <= rneg_r ? (32'd0 - nrem_s) : nrem_s;
            end
          end
        end
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: driver pushes model results, a monitor checks each done_o pulse.
module tb_hilo_muldiv_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        ready_o, stall_o, done_o, whi, wlo;
  logic [31:0] wHiData, wLoData;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whi;
    logic        wlo;
    int          lat;
    int          acc;
    logic [2:0]  op;
  } exp_t;
  exp_t sb[$];

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .ready_o(ready_o), .stall_o(stall_o), .done_o(done_o),
    .wHiData(wHiData), .whi(whi), .wLoData(wLoData), .wlo(wlo));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV truncating division
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb2, ma, mb, q, r;
    logic [63:0] p;
    e.hi = 32'd0; e.lo = 32'd0; e.whi = 1'b0; e.wlo = 1'b0; e.lat = 1; e.acc = 0; e.op = op;
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb2; e.hi = p[63:32]; e.lo = p[31:0]; e.whi = 1'b1; e.wlo = 1'b1; e.lat = MUL_LAT; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; e.whi = 1'b1; e.wlo = 1'b1; e.lat = MUL_LAT; end
      3'd3, 3'd4: begin
        if (op == 3'd4) begin sa = longint'({32'd0, a}); sb2 = longint'({32'd0, b}); end
        if (b != 32'd0) begin
          q = sa / sb2; r = sa % sb2;
          e.lo = q[31:0]; e.hi = r[31:0]; e.whi = 1'b1; e.wlo = 1'b1; e.lat = 33;
          ma = (sa < 0) ? -sa : sa;
          mb = (sb2 < 0) ? -sb2 : sb2;
`ifdef DIV_EARLY_EXIT_EN
          if (ma < mb) e.lat = 1;
`endif
        end
      end
      3'd5: begin e.hi = a; e.whi = 1'b1; end
      3'd6: begin e.lo = a; e.wlo = 1'b1; end
      default: e.lat = 0;
    endcase
    return e;
  endfunction

  // Issue one op when idle; push model result unless it is expected to be cancelled
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 200) begin @(negedge clk); n++; end
    check(ready_o == 1'b1, "ready_timeout", {63'd0, ready_o}, 64'd1);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    #1;
    check(stall_o == 1'b1, "stall_cycle0", {63'd0, stall_o}, 64'd1);
    e = model(op, a, b);
    e.acc = cyc;
    if (expect_done) sb.push_back(e);
    @(negedge clk);
    valid_i = 1'b0; op_i = 3'd0;
  endtask

  // Monitor: pop on every done_o, require quiet write port otherwise
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o) begin
        if (sb.size() == 0) begin
          check(1'b0, "spurious_done", {30'd0, whi, wlo, wHiData}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check(wHiData == e.hi && wLoData == e.lo, "done_data", {wHiData, wLoData}, {e.hi, e.lo});
          check(whi == e.whi && wlo == e.wlo, "done_we", {62'd0, whi, wlo}, {62'd0, e.whi, e.wlo});
          check(cyc - e.acc == e.lat, "done_latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end else begin
        check(!whi && !wlo && wHiData == 32'd0 && wLoData == 32'd0, "quiet_outputs",
              {30'd0, whi, wlo, wHiData | wLoData}, 64'd0);
      end
    end
  end

  initial begin
    int n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    #12;
    check(ready_o && !stall_o && !done_o && !whi && !wlo && wHiData == 32'd0 && wLoData == 32'd0,
          "reset_state", {59'd0, ready_o, stall_o, done_o, whi, wlo}, 64'h10);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd4, 32'd100, 32'd0, 1'b1);
    issue(3'd4, 32'd100, 32'd7, 1'b1);
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'd3, 32'd3, 32'd10, 1'b1);
    issue(3'd3, 32'd3, 32'd10, 1'b1);

    // Flush in cycle 10 of a divide
    issue(3'd4, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check(ready_o == 1'b1, "flush_ready", {63'd0, ready_o}, 64'd1);
    issue(3'd6, 32'h0000_1234, 32'd0, 1'b1);

    // Flush held during DONE must not suppress the write
    issue(3'd5, 32'hCAFE_0001, 32'd0, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;

    // Flush in the request cycle blocks acceptance
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd5; a_i = 32'h1111_2222; flush_i = 1'b1;
    #1;
    check(stall_o == 1'b0, "flush_req_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    valid_i = 1'b0; op_i = 3'd0; flush_i = 1'b0;
    check(ready_o == 1'b1, "flush_req_ready", {63'd0, ready_o}, 64'd1);

    // Request while busy is ignored
    issue(3'd4, 32'd100, 32'd7, 1'b1);
    valid_i = 1'b1; op_i = 3'd5; a_i = 32'hDEAD_BEEF;
    @(negedge clk);
    valid_i = 1'b0; op_i = 3'd0;

    // NONE opcodes are not accepted
    issue(3'd6, 32'h0000_00AA, 32'd0, 1'b1);
    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd7;
    #1;
    check(stall_o == 1'b0, "none_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk);
    valid_i = 1'b0; op_i = 3'd0;
    check(ready_o == 1'b1, "none_ready", {63'd0, ready_o}, 64'd1);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'd0;
        default: ra = 32'($urandom_range(0, 50));
      endcase
      issue(rop, ra, rb, 1'b1);
    end

    // Reset in cycle 1 of a multiply
    issue(3'd1, 32'd7, 32'd9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check(!done_o && !whi && !wlo && wHiData == 32'd0 && wLoData == 32'd0 && ready_o,
          "reset_midop", {59'd0, ready_o, stall_o, done_o, whi, wlo}, 64'h10);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check(ready_o == 1'b1, "post_reset_ready", {63'd0, ready_o}, 64'd1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check(sb.size() == 0, "drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
